ram_pec_banked_arb: RTL and testbench

- Parametrised successor to the single-port PEC SRAM wrapper.
- Address space is split into NUM_BANK single-port banks, interleaved by the low address bits.
- Each bank has a one-entry write-pending buffer (WPB), so reads always win the macro and no longer stall behind writes.
- Sits between the PEC control logic and the SRAM macros. Provides 1-cycle read latency, held read data, and write-buffer forwarding.

---
 rtl/ram_pec_pkg.sv | 33 +++
 rtl/ram_pec_bank_sp.sv | 61 ++++++
 rtl/ram_pec_banked_arb.sv | 202 ++++++++++++++++++++
 tb/tb_ram_pec_banked_arb.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_pec_pkg
// Description : Shared definitions for the banked PEC SRAM wrapper: default
//               geometry, the write-pending-buffer entry layout and helpers
//               that split a word address into bank index and bank row.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_pec_pkg;

    localparam int c_SRAM_WIDTH_DEF     = 28;
    localparam int c_SRAM_DEPTH_BIT_DEF = 6;
    localparam int c_BANK_BIT_DEF       = 1;

    // Write-pending-buffer entry at the default geometry.
    typedef struct packed {
        logic                            valid;
        logic [c_SRAM_DEPTH_BIT_DEF-1:0] addr;
        logic [c_SRAM_WIDTH_DEF-1:0]     data;
    } wpb_entry_t;

    // Banks are interleaved on the low address bits.
    function automatic logic [31:0] bank_of(input logic [31:0] addr, input int bank_bit);
        return addr & ((32'd1 << bank_bit) - 32'd1);
    endfunction

    // Row inside a bank: the address with the bank-select bits stripped.
    function automatic logic [31:0] row_of(input logic [31:0] addr, input int bank_bit);
        return addr >> bank_bit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_pec_bank_sp.sv
`default_nettype none
// ============================================================================
// Module      : ram_pec_bank_sp
// Description : One single-port synchronous SRAM bank. A behavioural array is
//               used unless PEC_SRAM_MACRO selects the hard macro.
//               Pins (macro naming):
//                 CK  - clock
//                 CSB - chip select, active low
//                 WEB - write enable, active low (1 = read)
//                 A   - row address
//                 DI  - write data
//                 DO  - read data, valid the cycle after a read, held otherwise
// Revision    : 1.0 - initial release
// ============================================================================
module ram_pec_bank_sp
    import ram_pec_pkg::*;
#(
    parameter int ADDR_W = c_SRAM_DEPTH_BIT_DEF - c_BANK_BIT_DEF,
    parameter int DATA_W = c_SRAM_WIDTH_DEF
) (
    input  logic              CK,
    input  logic              CSB,
    input  logic              WEB,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] DI,
    output logic [DATA_W-1:0] DO
);

`ifdef PEC_SRAM_MACRO
    SRAM_SP_MACRO #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_macro (
        .CK  (CK),
        .CSB (CSB),
        .WEB (WEB),
        .A   (A),
        .DI  (DI),
        .DO  (DO)
    );
`else
    // Behavioural bank (SYNTH_MINI and simulation builds). Contents are not
    // reset; DO keeps the last read word like the macro's output latch.
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_do;

    always_ff @(posedge CK) begin
        if (!CSB) begin
            if (!WEB) begin
                r_mem[A] <= DI;
            end else begin
                r_do <= r_mem[A];
            end
        end
    end

    assign DO = r_do;
`endif

endmodule
`default_nettype wire

// File: rtl/ram_pec_banked_arb.sv
`default_nettype none
// ============================================================================
// Module      : ram_pec_banked_arb
// Description : Banked single-port PEC SRAM wrapper. Each bank owns a
//               one-entry write-pending buffer (WPB) so reads always win the
//               macro; buffered writes drain on idle cycles and are forwarded
//               to reads of the same address.
//   clk, rst      - clock, asynchronous active-high reset
//   i_rd_en/addr  - read request, always accepted
//   i_wr_en/addr/data - write request, held by the master while o_wr_busy
//   o_wr_busy     - combinational: write not accepted this cycle
//   o_rd_valid    - response for the previous cycle's read
//   o_rd_data     - read data, held until the next o_rd_valid
// Revision    : 1.0 - initial release
// ============================================================================
module ram_pec_banked_arb
    import ram_pec_pkg::*;
#(
    parameter int SRAM_DEPTH_BIT = c_SRAM_DEPTH_BIT_DEF,
    parameter int SRAM_WIDTH     = c_SRAM_WIDTH_DEF,
    parameter int BANK_BIT       = c_BANK_BIT_DEF,
    parameter int NUM_BANK       = 2**BANK_BIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_rd_en,
    input  logic [SRAM_DEPTH_BIT-1:0] i_rd_addr,
    input  logic                      i_wr_en,
    input  logic [SRAM_DEPTH_BIT-1:0] i_wr_addr,
    input  logic [SRAM_WIDTH-1:0]     i_wr_data,
    output logic                      o_wr_busy,
    output logic                      o_rd_valid,
    output logic [SRAM_WIDTH-1:0]     o_rd_data
);

    // A single bank still needs a one-bit index signal.
    localparam int c_BANK_W = (BANK_BIT == 0) ? 1 : BANK_BIT;
    localparam int c_ROW_W  = SRAM_DEPTH_BIT - BANK_BIT;

    logic [c_BANK_W-1:0] w_rd_bank;
    logic [c_BANK_W-1:0] w_wr_bank;
    logic [c_ROW_W-1:0]  w_rd_row;
    logic [c_ROW_W-1:0]  w_wr_row;

    assign w_rd_bank = c_BANK_W'(bank_of(32'(i_rd_addr), BANK_BIT));
    assign w_wr_bank = c_BANK_W'(bank_of(32'(i_wr_addr), BANK_BIT));
    assign w_rd_row  = c_ROW_W'(row_of(32'(i_rd_addr), BANK_BIT));
    assign w_wr_row  = c_ROW_W'(row_of(32'(i_wr_addr), BANK_BIT));

    // Per-bank views exported from the generate loop.
    logic                      w_busy      [NUM_BANK];
    logic                      w_wpb_valid [NUM_BANK];
    logic [SRAM_DEPTH_BIT-1:0] w_wpb_addr  [NUM_BANK];
    logic [SRAM_WIDTH-1:0]     w_wpb_data  [NUM_BANK];
    logic [SRAM_WIDTH-1:0]     w_do        [NUM_BANK];

    generate
        for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
            logic                      r_valid;
            logic [SRAM_DEPTH_BIT-1:0] r_addr;
            logic [SRAM_WIDTH-1:0]     r_data;

            logic                      w_rd_hit;
            logic                      w_wr_hit;
            logic                      w_same;
            logic                      w_cap;
            logic                      w_drain;
            logic                      w_busy_b;
            logic                      w_csb;
            logic                      w_web;
            logic [c_ROW_W-1:0]        w_a;
            logic [c_ROW_W-1:0]        w_wpb_row;
            logic [SRAM_WIDTH-1:0]     w_di;
            logic [SRAM_WIDTH-1:0]     w_do_b;

            assign w_rd_hit  = i_rd_en && (w_rd_bank == c_BANK_W'(b));
            assign w_wr_hit  = i_wr_en && (w_wr_bank == c_BANK_W'(b));
            assign w_same    = r_valid && (r_addr == i_wr_addr);
            assign w_wpb_row = c_ROW_W'(row_of(32'(r_addr), BANK_BIT));

            always_comb begin
                w_cap    = 1'b0;
                w_drain  = 1'b0;
                w_busy_b = 1'b0;
                w_csb    = 1'b1;
                w_web    = 1'b1;
                w_a      = w_rd_row;
                w_di     = r_data;
                if (w_rd_hit) begin
                    // Read owns the macro; a write may only land in the WPB.
                    w_csb = 1'b0;
                    if (w_wr_hit) begin
                        if (!r_valid || w_same) begin
                            w_cap = 1'b1;
                        end else begin
                            w_busy_b = 1'b1;
                        end
                    end
                end else if (r_valid && w_wr_hit) begin
                    // Same address coalesces with the macro idle; otherwise
                    // retire the old entry and buffer the new one.
                    w_cap = 1'b1;
                    if (!w_same) begin
                        w_csb = 1'b0;
                        w_web = 1'b0;
                        w_a   = w_wpb_row;
                    end
                end else if (r_valid) begin
                    w_drain = 1'b1;
                    w_csb   = 1'b0;
                    w_web   = 1'b0;
                    w_a     = w_wpb_row;
                end else if (w_wr_hit) begin
                    w_csb = 1'b0;
                    w_web = 1'b0;
                    w_a   = w_wr_row;
                    w_di  = i_wr_data;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_addr  <= '0;
                    r_data  <= '0;
                end else if (w_cap) begin
                    r_valid <= 1'b1;
                    r_addr  <= i_wr_addr;
                    r_data  <= i_wr_data;
                end else if (w_drain) begin
                    r_valid <= 1'b0;
                end
            end

            ram_pec_bank_sp #(
                .ADDR_W (c_ROW_W),
                .DATA_W (SRAM_WIDTH)
            ) u_bank (
                .CK  (clk),
                .CSB (w_csb),
                .WEB (w_web),
                .A   (w_a),
                .DI  (w_di),
                .DO  (w_do_b)
            );

            assign w_busy[b]      = w_busy_b;
            assign w_wpb_valid[b] = r_valid;
            assign w_wpb_addr[b]  = r_addr;
            assign w_wpb_data[b]  = r_data;
            assign w_do[b]        = w_do_b;
        end
    endgenerate

    always_comb begin
        o_wr_busy = 1'b0;
        for (int k = 0; k < NUM_BANK; k++) begin
            o_wr_busy = o_wr_busy | w_busy[k];
        end
    end

    // Forwarding uses the WPB contents before this cycle's write, which gives
    // read-before-write ordering for a same-cycle read and write.
    logic w_fwd_now;
    assign w_fwd_now = w_wpb_valid[w_rd_bank] && (w_wpb_addr[w_rd_bank] == i_rd_addr);

    logic                  r_rd_valid;
    logic [c_BANK_W-1:0]   r_rd_bank;
    logic                  r_fwd;
    logic [SRAM_WIDTH-1:0] r_fwd_data;
    logic [SRAM_WIDTH-1:0] r_hold;
    logic [SRAM_WIDTH-1:0] w_resp;

    assign w_resp = r_fwd ? r_fwd_data : w_do[r_rd_bank];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_bank  <= '0;
            r_fwd      <= 1'b0;
            r_fwd_data <= '0;
            r_hold     <= '0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                r_rd_bank <= w_rd_bank;
                r_fwd     <= w_fwd_now;
                if (w_fwd_now) begin
                    r_fwd_data <= w_wpb_data[w_rd_bank];
                end
            end
            if (r_rd_valid) begin
                r_hold <= w_resp;
            end
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_valid ? w_resp : r_hold;

endmodule
`default_nettype wire

// File: tb/tb_ram_pec_banked_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_pec_banked_arb
// Description : Self-checking bench for ram_pec_banked_arb. A reference model
//               of the memory as seen by accepted writes predicts read data,
//               rd_valid and wr_busy every cycle; directed scenarios add
//               hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_pec_banked_arb;

    localparam int DB = 6;
    localparam int W  = 28;
    localparam int BB = 1;
    localparam int NB = 2**BB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_en = 1'b0;
    logic [DB-1:0] rd_addr = '0;
    logic          wr_en = 1'b0;
    logic [DB-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic          o_wr_busy;
    logic          o_rd_valid;
    logic [W-1:0]  o_rd_data;

    ram_pec_banked_arb #(
        .SRAM_DEPTH_BIT (DB),
        .SRAM_WIDTH     (W),
        .BANK_BIT       (BB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_rd_en    (rd_en),
        .i_rd_addr  (rd_addr),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .o_wr_busy  (o_wr_busy),
        .o_rd_valid (o_rd_valid),
        .o_rd_data  (o_rd_data)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_mem: value of every address as defined by accepted writes.
    // pend_*: which address, if any, is still parked per bank (only needed to
    // know when a write must be refused).
    logic [W-1:0]  m_mem   [2**DB];
    bit            m_known [2**DB];
    bit            pend_v  [NB];
    logic [DB-1:0] pend_a  [NB];
    bit            m_valid = 1'b0;
    logic [W-1:0]  m_data  = '0;
    bit            m_dknown = 1'b1;

    function automatic bit model_busy();
        int rb = int'(rd_addr) % NB;
        int wb = int'(wr_addr) % NB;
        return wr_en && rd_en && (rb == wb) && pend_v[wb] && (pend_a[wb] != wr_addr);
    endfunction

    task automatic model_step();
        bit busy;
        int rb;
        int wb;
        if (rst) begin
            m_valid  = 1'b0;
            m_data   = '0;
            m_dknown = 1'b1;
            for (int k = 0; k < NB; k++) pend_v[k] = 1'b0;
            for (int a = 0; a < 2**DB; a++) m_known[a] = 1'b0;
        end else begin
            busy = model_busy();
            rb   = int'(rd_addr) % NB;
            wb   = int'(wr_addr) % NB;
            if (rd_en) begin
                m_data   = m_mem[rd_addr];
                m_dknown = m_known[rd_addr];
            end
            m_valid = rd_en;
            for (int k = 0; k < NB; k++) begin
                bit rd_k = rd_en && (rb == k);
                bit wr_k = wr_en && !busy && (wb == k);
                if (wr_k) begin
                    if (rd_k || pend_v[k]) begin
                        pend_v[k] = 1'b1;
                        pend_a[k] = wr_addr;
                    end else begin
                        pend_v[k] = 1'b0;
                    end
                end else if (!rd_k) begin
                    pend_v[k] = 1'b0;
                end
            end
            if (wr_en && !busy) begin
                m_mem[wr_addr]   = wr_data;
                m_known[wr_addr] = 1'b1;
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 2**DB; a++) m_known[a] = 1'b0;
        for (int k = 0; k < NB; k++) begin
            pend_v[k] = 1'b0;
            pend_a[k] = '0;
        end
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Compare process: outputs against the model on every cycle out of reset.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rd_valid", 32'(o_rd_valid), 32'(m_valid));
                if (m_dknown) chk("rd_data", 32'(o_rd_data), 32'(m_data));
                chk("wr_busy", 32'(o_wr_busy), 32'(model_busy()));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic r, input logic [DB-1:0] ra,
                         input logic w, input logic [DB-1:0] wa, input logic [W-1:0] wd);
        rd_en   = r;
        rd_addr = ra;
        wr_en   = w;
        wr_addr = wa;
        wr_data = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic r, input logic [DB-1:0] ra,
                       input logic w, input logic [DB-1:0] wa, input logic [W-1:0] wd);
        drive(r, ra, w, wa, wd);
        tick();
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic lit_rd(input string name, input logic [W-1:0] exp);
        chk({name, "_valid"}, 32'(o_rd_valid), 32'd1);
        chk(name, 32'(o_rd_data), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        idle();

        // Reset while a read is in flight: no response, data cleared.
        cyc(1'b1, 6'd5, 1'b0, '0, '0);
        drive(1'b0, '0, 1'b0, '0, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_rd_valid", 32'(o_rd_valid), 32'd0);
        chk("rst_rd_data", 32'(o_rd_data), 32'd0);
        idle();
        chk("rst_rd_valid_after", 32'(o_rd_valid), 32'd0);

        // Plain write then read, with data held afterwards.
        cyc(1'b0, '0, 1'b1, 6'd6, 28'hABCDEF0);
        idle();
        idle();
        cyc(1'b1, 6'd6, 1'b0, '0, '0);
        lit_rd("plain_rd", 28'hABCDEF0);
        idle();
        chk("plain_hold_valid", 32'(o_rd_valid), 32'd0);
        chk("plain_hold_data", 32'(o_rd_data), 32'hABCDEF0);

        // Bank-0 read/write conflict: first write buffered, second refused.
        drive(1'b1, 6'd2, 1'b1, 6'd4, 28'h11);
        #1 chk("conf_busy_first", 32'(o_wr_busy), 32'd0);
        tick();
        drive(1'b1, 6'd2, 1'b1, 6'd8, 28'h22);
        #1 chk("conf_busy_second", 32'(o_wr_busy), 32'd1);
        tick();
        #1 chk("conf_busy_held", 32'(o_wr_busy), 32'd1);
        tick();
        drive(1'b0, '0, 1'b1, 6'd8, 28'h22);
        #1 chk("conf_busy_release", 32'(o_wr_busy), 32'd0);
        tick();
        idle();
        idle();
        cyc(1'b1, 6'd4, 1'b0, '0, '0);
        lit_rd("conf_rd4", 28'h11);
        cyc(1'b1, 6'd8, 1'b0, '0, '0);
        lit_rd("conf_rd8", 28'h22);
        idle();

        // Forwarding from the WPB while the read holds the bank.
        drive(1'b1, 6'd0, 1'b1, 6'd2, 28'h55);
        #1 chk("fwd_busy", 32'(o_wr_busy), 32'd0);
        tick();
        cyc(1'b1, 6'd2, 1'b0, '0, '0);
        lit_rd("fwd_rd2", 28'h55);
        idle();

        // Coalesce under continuous bank-0 reads.
        cyc(1'b1, 6'd0, 1'b1, 6'd6, 28'h1);
        drive(1'b1, 6'd0, 1'b1, 6'd6, 28'h2);
        #1 chk("coal_busy", 32'(o_wr_busy), 32'd0);
        tick();
        cyc(1'b1, 6'd6, 1'b0, '0, '0);
        lit_rd("coal_rd6_fwd", 28'h2);
        idle();
        idle();
        cyc(1'b1, 6'd6, 1'b0, '0, '0);
        lit_rd("coal_rd6_mem", 28'h2);

        // Same-cycle read and write of one address: read sees the old value.
        cyc(1'b0, '0, 1'b1, 6'd10, 28'h7);
        idle();
        idle();
        cyc(1'b1, 6'd10, 1'b1, 6'd10, 28'h9);
        lit_rd("raw_old", 28'h7);
        cyc(1'b1, 6'd10, 1'b0, '0, '0);
        lit_rd("raw_new", 28'h9);
        idle();

        // Reads on bank 1 never block writes on bank 0.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 6'd1, 1'b1, 6'(2 * i), 28'(32'h100 + i));
            #1 chk($sformatf("xbank_busy_%0d", i), 32'(o_wr_busy), 32'd0);
            tick();
        end
        idle();
        idle();
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 6'(2 * i), 1'b0, '0, '0);
            lit_rd($sformatf("xbank_rd_%0d", i), 28'(32'h100 + i));
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
